// File: rtl/con_pkg.sv
// Shared types for the branch-condition unit: condition codes, operand FSM states
// and the two-operand code classifier.
package con_pkg;

    typedef enum logic [3:0] {
        CondNever   = 4'd0,
        CondAlways  = 4'd1,
        CondZero    = 4'd2,
        CondNonzero = 4'd3,
        CondPlus    = 4'd4,
        CondMinus   = 4'd5,
        CondEq      = 4'd6,
        CondNe      = 4'd7,
        CondLt      = 4'd8,
        CondGe      = 4'd9,
        CondLtu     = 4'd10,
        CondGeu     = 4'd11,
        CondDecnz   = 4'd12
    } cond_e;

    typedef enum logic [0:0] {
        StEmpty = 1'b0,
        StHeld  = 1'b1
    } op_state_e;

    function automatic logic is_two_op(cond_e c);
        return (c >= CondEq) && (c <= CondGeu);
    endfunction

endpackage

// File: rtl/con_cmp.sv
// Combinational two-operand comparator: evaluates A against B for the
// EQ/NE/LT/GE/LTU/GEU codes; any other code yields 0.
module con_cmp
    import con_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  cond_e        code,
    output logic         res
);

    logic eq, lt_s, lt_u;

    assign eq   = (a == b);
    assign lt_s = ($signed(a) < $signed(b));
    assign lt_u = (a < b);

    always_comb begin
        res = 1'b0;
        case (code)
            CondEq:  res = eq;
            CondNe:  res = !eq;
            CondLt:  res = lt_s;
            CondGe:  res = !lt_s;
            CondLtu: res = lt_u;
            CondGeu: res = !lt_u;
            default: res = 1'b0;
        endcase
    end

endmodule

// File: rtl/con_unit_p.sv
// Branch-condition unit: evaluates IR condition field against the bus, with a held
// operand A, a decrement-and-test loop counter, a valid pulse and a sticky illegal flag.
module con_unit_p
    import con_pkg::*;
#(
    parameter int unsigned W       = 32,
    parameter int unsigned CON_MSB = 3,
    parameter int unsigned CON_LSB = 0,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     bus,
    input  logic [W-1:0]     IR,
    input  logic             cap_a,
    input  logic             ld_cnt,
    input  logic             con_in,
    input  logic             ill_clr,
    output logic             con_out,
    output logic             con_valid,
    output logic             a_valid,
    output logic             illegal,
    output logic [CNT_W-1:0] cnt
);

    op_state_e        state_q;
    logic [W-1:0]     a_q;
    logic [CNT_W-1:0] cnt_q;
    logic             con_out_q, con_valid_q, illegal_q;

    cond_e code;
    logic  two_op, missing, reserved, cmp_res, cond_val;

    // Only the condition field is decoded; the rest of IR is don't-care here.
    logic unused_ir;
    assign unused_ir = ^IR;

    assign code     = cond_e'(IR[CON_MSB:CON_LSB]);
    assign two_op   = is_two_op(code);
    assign missing  = two_op && (state_q == StEmpty);
    assign reserved = (IR[CON_MSB:CON_LSB] > 4'd12);

    con_cmp #(
        .W (W)
    ) u_cmp (
        .a    (a_q),
        .b    (bus),
        .code (code),
        .res  (cmp_res)
    );

    always_comb begin
        cond_val = 1'b0;
        case (code)
            CondNever:   cond_val = 1'b0;
            CondAlways:  cond_val = 1'b1;
            CondZero:    cond_val = (bus == '0);
            CondNonzero: cond_val = (bus != '0);
            CondPlus:    cond_val = !bus[W-1];
            CondMinus:   cond_val = bus[W-1];
            CondDecnz:   cond_val = (cnt_q != CNT_W'(1));  // cnt-1 != 0, wrap at 0 gives 1
            default:     cond_val = cmp_res;
        endcase
        if (missing || reserved) begin
            cond_val = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StEmpty;
            a_q         <= '0;
            cnt_q       <= '0;
            con_out_q   <= 1'b0;
            con_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            con_valid_q <= con_in;
            if (con_in) begin
                con_out_q <= cond_val;
            end

            // Capture wins over consumption so cap_a alongside a compare keeps HELD.
            if (cap_a) begin
                a_q     <= bus;
                state_q <= StHeld;
            end else if (con_in && two_op && (state_q == StHeld)) begin
                state_q <= StEmpty;
            end

            if (ld_cnt) begin
                cnt_q <= bus[CNT_W-1:0];
            end else if (con_in && (code == CondDecnz)) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end

            if (con_in && (reserved || missing)) begin
                illegal_q <= 1'b1;
            end else if (ill_clr) begin
                illegal_q <= 1'b0;
            end
        end
    end

    assign con_out   = con_out_q;
    assign con_valid = con_valid_q;
    assign a_valid   = (state_q == StHeld);
    assign illegal   = illegal_q;
    assign cnt       = cnt_q;

endmodule

// File: tb/tb_con_unit_p.sv
// Directed self-checking bench for con_unit_p with hand-computed expectations.
module tb_con_unit_p;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] bus, IR;
    logic        cap_a, ld_cnt, con_in, ill_clr;
    logic        con_out, con_valid, a_valid, illegal;
    logic [15:0] cnt;

    int checks   = 0;
    int failures = 0;

    con_unit_p #(
        .W       (32),
        .CON_MSB (3),
        .CON_LSB (0),
        .CNT_W   (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .IR        (IR),
        .cap_a     (cap_a),
        .ld_cnt    (ld_cnt),
        .con_in    (con_in),
        .ill_clr   (ill_clr),
        .con_out   (con_out),
        .con_valid (con_valid),
        .a_valid   (a_valid),
        .illegal   (illegal),
        .cnt       (cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        cap_a = 0; ld_cnt = 0; con_in = 0; ill_clr = 0;
    endtask

    // One evaluation: drive code/bus with con_in for a single edge.
    task automatic eval(input logic [3:0] code, input logic [31:0] b);
        idle();
        IR = {28'd0, code}; bus = b; con_in = 1;
        tick();
        con_in = 0;
    endtask

    initial begin
        rst = 0; bus = 0; IR = 32'd1;
        cap_a = 0; ld_cnt = 0; con_in = 1; ill_clr = 0;
        tick(); tick();
        chk("rst_con_out", {31'd0, con_out}, 0);
        chk("rst_con_valid", {31'd0, con_valid}, 0);
        chk("rst_a_valid", {31'd0, a_valid}, 0);
        chk("rst_illegal", {31'd0, illegal}, 0);
        chk("rst_cnt", {16'd0, cnt}, 0);

        rst = 1;
        tick();
        chk("always_out", {31'd0, con_out}, 1);
        chk("always_valid", {31'd0, con_valid}, 1);
        con_in = 0;
        tick();
        chk("valid_drop", {31'd0, con_valid}, 0);
        chk("out_hold", {31'd0, con_out}, 1);

        eval(4'd2, 32'h0);
        chk("zero", {31'd0, con_out}, 1);
        eval(4'd5, 32'h8000_0000);
        chk("minus", {31'd0, con_out}, 1);
        eval(4'd4, 32'h8000_0000);
        chk("plus", {31'd0, con_out}, 0);
        eval(4'd3, 32'h0);
        chk("nonzero", {31'd0, con_out}, 0);

        // Signed vs unsigned.
        idle(); cap_a = 1; bus = 32'hFFFF_FFFF; tick(); idle();
        chk("cap_held", {31'd0, a_valid}, 1);
        eval(4'd8, 32'd1);
        chk("lt_signed", {31'd0, con_out}, 1);
        chk("lt_consumed", {31'd0, a_valid}, 0);
        idle(); cap_a = 1; bus = 32'hFFFF_FFFF; tick();
        eval(4'd10, 32'd1);
        chk("ltu", {31'd0, con_out}, 0);
        idle(); cap_a = 1; bus = 32'hFFFF_FFFF; tick();
        eval(4'd9, 32'd1);
        chk("ge_signed", {31'd0, con_out}, 0);
        idle(); cap_a = 1; bus = 32'hFFFF_FFFF; tick();
        eval(4'd11, 32'd1);
        chk("geu", {31'd0, con_out}, 1);
        chk("no_illegal_yet", {31'd0, illegal}, 0);

        // Missing operand and sticky flag.
        eval(4'd1, 32'd0);
        eval(4'd6, 32'd0);
        chk("missing_out", {31'd0, con_out}, 0);
        chk("missing_ill", {31'd0, illegal}, 1);
        eval(4'd1, 32'd0);
        chk("sticky_out", {31'd0, con_out}, 1);
        chk("sticky_ill", {31'd0, illegal}, 1);
        idle(); ill_clr = 1; tick(); idle();
        chk("ill_clr", {31'd0, illegal}, 0);
        eval(4'd14, 32'd0);
        chk("reserved_out", {31'd0, con_out}, 0);
        chk("reserved_ill", {31'd0, illegal}, 1);
        idle(); ill_clr = 1; tick(); idle();
        IR = 32'd13; con_in = 1; ill_clr = 1; tick(); idle();
        chk("set_wins", {31'd0, illegal}, 1);
        ill_clr = 1; tick(); idle();

        // Loop counter.
        ld_cnt = 1; bus = 32'd3; tick(); idle();
        chk("ld_cnt", {16'd0, cnt}, 3);
        eval(4'd12, 32'd0);
        chk("dec1_out", {31'd0, con_out}, 1);
        chk("dec1_cnt", {16'd0, cnt}, 2);
        eval(4'd12, 32'd0);
        chk("dec2_out", {31'd0, con_out}, 1);
        chk("dec2_cnt", {16'd0, cnt}, 1);
        eval(4'd12, 32'd0);
        chk("dec3_out", {31'd0, con_out}, 0);
        chk("dec3_cnt", {16'd0, cnt}, 0);
        eval(4'd12, 32'd0);
        chk("dec_wrap_out", {31'd0, con_out}, 1);
        chk("dec_wrap_cnt", {16'd0, cnt}, 32'hFFFF);

        // Back-to-back evaluations keep con_valid high.
        IR = 32'd1; con_in = 1; tick();
        IR = 32'd0; tick();
        chk("b2b_valid", {31'd0, con_valid}, 1);
        chk("b2b_out", {31'd0, con_out}, 0);
        idle();

        // Simultaneous capture and compare.
        cap_a = 1; bus = 32'd10; tick(); idle();
        cap_a = 1; con_in = 1; IR = 32'd7; bus = 32'd20; tick(); idle();
        chk("cap_cmp_out", {31'd0, con_out}, 1);
        chk("cap_cmp_held", {31'd0, a_valid}, 1);
        eval(4'd6, 32'd20);
        chk("new_a_eq", {31'd0, con_out}, 1);
        chk("new_a_consumed", {31'd0, a_valid}, 0);

        // Load priority over decrement.
        ld_cnt = 1; bus = 32'd1; tick(); idle();
        ld_cnt = 1; con_in = 1; IR = 32'd12; bus = 32'd5; tick(); idle();
        chk("ld_dec_out", {31'd0, con_out}, 0);
        chk("ld_dec_cnt", {16'd0, cnt}, 5);

        // Asynchronous reset mid-sequence.
        cap_a = 1; bus = 32'd7; tick();
        cap_a = 0; ld_cnt = 1; bus = 32'd9; con_in = 1; IR = 32'd1; tick(); idle();
        #2 rst = 0;
        #1;
        chk("mid_rst_a", {31'd0, a_valid}, 0);
        chk("mid_rst_cnt", {16'd0, cnt}, 0);
        chk("mid_rst_out", {31'd0, con_out}, 0);
        chk("mid_rst_valid", {31'd0, con_valid}, 0);
        tick();
        rst = 1;
        tick();
        chk("post_rst_valid", {31'd0, con_valid}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
